// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback buffer: entry layout and the
// register-file write-select encoding {enable, address}.
package wb_pkg;

  localparam int REG_AW    = 4;
  localparam int DATA_W    = 32;
  localparam int WR_EN_BIT = REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // A disabled port carries an all-zero select so the register file never sees a stale address.
  function automatic logic [REG_AW:0] mk_sel(input logic en, input logic [REG_AW-1:0] addr);
    logic [REG_AW:0] sel;
    sel                 = '0;
    sel[WR_EN_BIT]      = en;
    sel[REG_AW-1:0]     = en ? addr : '0;
    return sel;
  endfunction

endpackage

// File: rtl/wb_pending_match.sv
// Compares every valid queued entry's destination against three read-selects
// so operand fetch can stall on a write that has not yet reached the register file.
module wb_pending_match #(
  parameter int DEPTH = 8,
  parameter int AW    = 4
) (
  input  logic [DEPTH-1:0]         i_entryValid,
  input  logic [DEPTH-1:0][AW-1:0] i_entryAddr,
  input  logic [AW-1:0]            i_rdAddr0,
  input  logic [AW-1:0]            i_rdAddr1,
  input  logic [AW-1:0]            i_rdAddr2,
  output logic                     o_pend0,
  output logic                     o_pend1,
  output logic                     o_pend2
);

  always_comb begin
    o_pend0 = 1'b0;
    o_pend1 = 1'b0;
    o_pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_entryValid[i] && (i_entryAddr[i] == i_rdAddr0)) o_pend0 = 1'b1;
      if (i_entryValid[i] && (i_entryAddr[i] == i_rdAddr1)) o_pend1 = 1'b1;
      if (i_entryValid[i] && (i_entryAddr[i] == i_rdAddr2)) o_pend2 = 1'b1;
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// In-order writeback FIFO that drains up to two results per cycle into the
// register file's two write ports and flags read-selects with queued writes.
module wb_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = REG_AW,
  parameter int DW    = DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic [AW:0]              wr_sel0,
  output logic [DW-1:0]            wr_data0,
  output logic [AW:0]              wr_sel1,
  output logic [DW-1:0]            wr_data1,
  input  logic [AW-1:0]            rd_addr0,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     pend0,
  output logic                     pend1,
  output logic                     pend2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t              r_mem [DEPTH];
  logic [DEPTH-1:0]       r_valid;
  logic [PW-1:0]          r_wrPtr;
  logic [PW-1:0]          r_rdPtr;
  logic [PW:0]            r_count;

  logic [PW-1:0]          w_head1Ptr;
  wb_entry_t              w_head;
  wb_entry_t              w_next;
  wb_entry_t              w_pushEntry;
  logic                   w_en0;
  logic                   w_en1;
  logic                   w_push;
  logic                   w_inReady;
  logic [1:0]             w_pops;
  logic [DEPTH-1:0][AW-1:0] w_entryAddr;

  assign w_head1Ptr  = r_rdPtr + PW'(1);
  assign w_head      = r_mem[r_rdPtr];
  assign w_next      = r_mem[w_head1Ptr];
  assign w_pushEntry = '{addr: in_addr, data: in_data};

  // Full blocks accepts even when a pop happens the same edge; gating with rst_n holds ready low during reset.
  assign w_inReady = rst_n && (r_count < (PW+1)'(DEPTH));
  assign w_push    = in_valid && w_inReady;

  // Port 1 never carries port 0's address, or the register file would drop both writes.
  assign w_en0  = drain_en && (r_count != '0);
  assign w_en1  = drain_en && (r_count >= (PW+1)'(2)) && (w_next.addr != w_head.addr);
  assign w_pops = {1'b0, w_en0} + {1'b0, w_en1};

  assign in_ready = w_inReady;
  assign count    = r_count;
  assign wr_sel0  = mk_sel(w_en0, w_head.addr);
  assign wr_sel1  = mk_sel(w_en1, w_next.addr);
  assign wr_data0 = w_en0 ? w_head.data : '0;
  assign wr_data1 = w_en1 ? w_next.data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_en0) r_valid[r_rdPtr] <= 1'b0;
      if (w_en1) r_valid[w_head1Ptr] <= 1'b0;
      if (w_push) begin
        r_valid[r_wrPtr] <= 1'b1;
        r_wrPtr          <= r_wrPtr + PW'(1);
      end
      r_rdPtr <= r_rdPtr + PW'(w_pops);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pops);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushEntry;
  end

  always_comb begin
    w_entryAddr = '0;
    for (int i = 0; i < DEPTH; i++) w_entryAddr[i] = r_mem[i].addr;
  end

  wb_pending_match #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pendingMatch (
    .i_entryValid (r_valid),
    .i_entryAddr  (w_entryAddr),
    .i_rdAddr0    (rd_addr0),
    .i_rdAddr1    (rd_addr1),
    .i_rdAddr2    (rd_addr2),
    .o_pend0      (pend0),
    .o_pend1      (pend1),
    .o_pend2      (pend2)
  );

endmodule

// File: tb/tb_wb_buffer.sv
// Directed self-checking bench for wb_buffer: reset, dual drain, same-address
// serialisation, full/backpressure, pending flags and mid-drain reset.
module tb_wb_buffer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_addr;
  logic [31:0] in_data;
  logic        drain_en;
  logic [4:0]  wr_sel0;
  logic [31:0] wr_data0;
  logic [4:0]  wr_sel1;
  logic [31:0] wr_data1;
  logic [3:0]  rd_addr0;
  logic [3:0]  rd_addr1;
  logic [3:0]  rd_addr2;
  logic        pend0;
  logic        pend1;
  logic        pend2;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  wb_buffer #(.DEPTH(8), .AW(4), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .drain_en (drain_en),
    .wr_sel0  (wr_sel0),
    .wr_data0 (wr_data0),
    .wr_sel1  (wr_sel1),
    .wr_data1 (wr_data1),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .pend0    (pend0),
    .pend1    (pend1),
    .pend2    (pend2),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    drain_en = 1'b0;
    rd_addr0 = 4'd0;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;

    // Reset held three cycles, then released.
    repeat (3) tick();
    checkOutput("rst_in_ready_low", in_ready, 1'b0);
    checkOutput("rst_sel0_zero", wr_sel0, 5'b0_0000);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_count", count, 4'd0);
    checkOutput("idle_in_ready", in_ready, 1'b1);
    checkOutput("idle_sel0", wr_sel0, 5'b0_0000);
    checkOutput("idle_sel1", wr_sel1, 5'b0_0000);
    checkOutput("idle_pend", {pend0, pend1, pend2}, 3'b000);

    // Two different addresses drain together.
    applyStimulus(4'd3, 32'h11);
    applyStimulus(4'd7, 32'h22);
    checkOutput("dual_count_before", count, 4'd2);
    checkOutput("dual_held_sel0", wr_sel0, 5'b0_0000);
    drain_en = 1'b1;
    #1;
    checkOutput("dual_sel0", wr_sel0, 5'b1_0011);
    checkOutput("dual_data0", wr_data0, 32'h11);
    checkOutput("dual_sel1", wr_sel1, 5'b1_0111);
    checkOutput("dual_data1", wr_data1, 32'h22);
    tick();
    drain_en = 1'b0;
    checkOutput("dual_count_after", count, 4'd0);

    // Same address twice must serialise in program order.
    applyStimulus(4'd5, 32'hA);
    applyStimulus(4'd5, 32'hB);
    drain_en = 1'b1;
    #1;
    checkOutput("same_c1_sel0", wr_sel0, 5'b1_0101);
    checkOutput("same_c1_data0", wr_data0, 32'hA);
    checkOutput("same_c1_sel1", wr_sel1, 5'b0_0000);
    checkOutput("same_c1_data1", wr_data1, 32'h0);
    tick();
    checkOutput("same_c2_count", count, 4'd1);
    checkOutput("same_c2_sel0", wr_sel0, 5'b1_0101);
    checkOutput("same_c2_data0", wr_data0, 32'hB);
    checkOutput("same_c2_sel1", wr_sel1, 5'b0_0000);
    tick();
    checkOutput("same_done_count", count, 4'd0);
    drain_en = 1'b0;

    // Fill to full, then pop two while in_valid is held: no accept on that edge.
    for (int i = 0; i < 8; i++) applyStimulus(4'(i), 32'h100 + 32'(i));
    checkOutput("full_count", count, 4'd8);
    checkOutput("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_addr  = 4'hE;
    in_data  = 32'hEE;
    drain_en = 1'b1;
    #1;
    checkOutput("full_pop_in_ready", in_ready, 1'b0);
    checkOutput("full_pop_sel0", wr_sel0, 5'b1_0000);
    checkOutput("full_pop_sel1", wr_sel1, 5'b1_0001);
    checkOutput("full_pop_data1", wr_data1, 32'h101);
    tick();
    drain_en = 1'b0;
    checkOutput("full_after_pop_count", count, 4'd6);
    checkOutput("full_after_pop_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    checkOutput("full_accept_count", count, 4'd7);
    drain_en = 1'b1;
    #1;
    checkOutput("wrap_head_data0", wr_data0, 32'h102);
    checkOutput("wrap_head_data1", wr_data1, 32'h103);
    repeat (3) tick();
    checkOutput("wrap_last_sel0", wr_sel0, 5'b1_1110);
    checkOutput("wrap_last_data0", wr_data0, 32'hEE);
    checkOutput("wrap_last_sel1", wr_sel1, 5'b0_0000);
    tick();
    checkOutput("wrap_empty_count", count, 4'd0);
    drain_en = 1'b0;

    // Pending flag: accepting entry excluded, queued entry counted through its issue cycle.
    rd_addr0 = 4'd2;
    rd_addr1 = 4'd9;
    rd_addr2 = 4'd4;
    in_valid = 1'b1;
    in_addr  = 4'd9;
    in_data  = 32'h99;
    #1;
    checkOutput("pend_accepting_excluded", pend1, 1'b0);
    tick();
    in_valid = 1'b0;
    checkOutput("pend_queued", {pend0, pend1, pend2}, 3'b010);
    drain_en = 1'b1;
    #1;
    checkOutput("pend_issue_sel0", wr_sel0, 5'b1_1001);
    checkOutput("pend_issue_still", pend1, 1'b1);
    tick();
    drain_en = 1'b0;
    checkOutput("pend_after_pop", pend1, 1'b0);
    checkOutput("pend_after_count", count, 4'd0);

    // Mid-drain asynchronous reset discards everything.
    for (int i = 1; i <= 5; i++) applyStimulus(4'(i), 32'h200 + 32'(i));
    drain_en = 1'b1;
    #1;
    checkOutput("mid_sel0_before", wr_sel0, 5'b1_0001);
    tick();
    checkOutput("mid_count_before", count, 4'd3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sel0", wr_sel0, 5'b0_0000);
    checkOutput("mid_rst_sel1", wr_sel1, 5'b0_0000);
    checkOutput("mid_rst_data0", wr_data0, 32'h0);
    checkOutput("mid_rst_count", count, 4'd0);
    checkOutput("mid_rst_ready", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_sel0", wr_sel0, 5'b0_0000);
    checkOutput("post_rst_sel1", wr_sel1, 5'b0_0000);
    tick();
    checkOutput("post_rst_sel0_next", wr_sel0, 5'b0_0000);
    checkOutput("post_rst_count", count, 4'd0);
    checkOutput("post_rst_pend", {pend0, pend1, pend2}, 3'b000);
    drain_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
